ssp_param: RTL and testbench
============================

// Module: ssp_param
// PURPOSE
//  Parametrised synchronous serial port: APB-style write/read into TX/RX FIFOs, serializer, deserializer.
//  Single PCLK domain; serial clock in is oversampled, serial clock out is a divided PCLK.
//  Successor to the fixed 8-bit SSP. Adds width/depth/divider parameters, back-to-back frames and an RX overrun flag.
// PARAMETERS
//  DATA_WIDTH  8  frame/word width in bits, >=4
//  TX_DEPTH    4  TX FIFO entries, power of 2, >=2
//  RX_DEPTH    4  RX FIFO entries, power of 2, >=2
//  CLK_DIV     2  SSPCLKOUT half-period in PCLK cycles, >=1
// PORTS
//  PCLK       in   1           sole clock, rising edge
//  CLEAR      in   1           asynchronous reset, active-high
//  PSEL       in   1           bus select
//  PWRITE     in   1           1=push TX FIFO, 0=pop RX FIFO (qualified by PSEL)
//  PWDATA     in   DATA_WIDTH  write data
//  PRDATA     out  DATA_WIDTH  read data, registered
//  SSPCLKIN   in   1           rx serial clock, async, <=PCLK/8
//  SSPFSSIN   in   1           rx frame sync, async
//  SSPRXD     in   1           rx serial data, async
//  SSPCLKOUT  out  1           tx serial clock
//  SSPFSSOUT  out  1           tx frame sync
//  SSPTXD     out  1           tx serial data, MSB first
//  SSPOE_B    out  1           tx output enable, active-low
//  SSPTXINTR  out  1           TX FIFO full
//  SSPRXINTR  out  1           RX FIFO full
//  SSPRXOVR   out  1           sticky RX overrun
// BEHAVIOUR
//  Reset: all outputs 0 except SSPOE_B=1. FIFOs are empty, FSM=IDLE, dividers cleared. Reset mid-frame abandons the frame at once.
//  Write: PSEL&PWRITE and TX not full -> push PWDATA. Write while full is dropped.
//    Push and pop in the same cycle on a full FIFO: both take effect.
//  Read: PSEL&!PWRITE and RX not empty -> PRDATA<=head next cycle, pop. Read of an empty FIFO -> PRDATA<=0.
//  SSPTXINTR and SSPRXINTR are registered FIFO-full flags, updated the cycle after the push/pop.
//  TX FSM IDLE->FRAME->SHIFT:
//    IDLE: SSPCLKOUT=0. If TX not empty, pop into the shift register and go to FRAME on the next PCLK.
//    FRAME: SSPFSSOUT=1 for one SSPCLKOUT period (2*CLK_DIV PCLK cycles).
//    SHIFT: DATA_WIDTH SSPCLKOUT periods. SSPTXD changes on the SSPCLKOUT rising edge. SSPOE_B=0.
//    Last bit: if TX is not empty, pop and go to FRAME with no idle gap; otherwise go to IDLE, SSPOE_B=1, SSPTXD=0.
//    SSPCLKOUT toggles only in FRAME and SHIFT. Divider counter is $clog2(CLK_DIV+1) bits, wraps at CLK_DIV-1.
//  RX: SSPCLKIN, SSPFSSIN and SSPRXD each pass a 2-flop synchronizer; edges are detected from the synced clock.
//    Synced SSPCLKIN rising with SSPFSSIN=1 arms the receiver.
//    Each subsequent synced falling edge samples SSPRXD MSB-first.
//    After DATA_WIDTH samples: push to RX if not full; if full, drop the word and set SSPRXOVR=1 (cleared only by CLEAR).
//    Bit counter is $clog2(DATA_WIDTH+1) bits and resets when a new frame arms.
//    FSSIN reasserted mid-word re-arms the receiver and discards partial bits.
// CONFIGURATION
//  SSP_LOOPBACK_EN defined: adds input port LPBK (1 bit).
//    LPBK=1: the RX path takes the internal SSPCLKOUT/SSPFSSOUT/SSPTXD through the same synchronizers; external RX pins are ignored.
//  Undefined: no LPBK port; RX always uses the external pins.
// STRUCTURE
//  Package ssp_pkg: tx_state_t enum {IDLE,FRAME,SHIFT}; localparams for pointer/counter widths via $clog2.
//  Sub-module ssp_fifo (parametrised sync FIFO, WIDTH/DEPTH, full/empty, push/pop), instanced twice (TX, RX).
// TESTING
//  Reset: hold CLEAR 3 cycles -> all outputs 0, SSPOE_B=1, PRDATA=0, both FIFOs empty.
//  Write 0xA5, CLK_DIV=2 -> SSPFSSOUT high 4 PCLK, then SSPTXD=1,0,1,0,0,1,0,1, each bit 4 PCLK. SSPOE_B low 32 PCLK.
//  Write 0x3C,0xC3 back-to-back -> second FRAME starts on the PCLK after the first word's last bit; SSPOE_B returns to 1 after the second word.
//  5 writes with TX_DEPTH=4 while idle-blocked -> SSPTXINTR=1 after the 4th; the 5th is dropped; 4 words transmitted.
//  Drive external frame 0x81 with SSPCLKIN=PCLK/8 -> RX holds 0x81; read -> PRDATA=0x81 next cycle; a further read -> 0.
//  5 RX frames with no reads -> SSPRXINTR=1 after 4; the 5th sets SSPRXOVR=1. LPBK=1 plus write 0x5A -> RX reads 0x5A.

Source files
------------

// File: rtl/ssp_pkg.sv
// Shared types and width helpers for the parametrised synchronous serial port.
// Optional loopback is enabled by defining SSP_LOOPBACK_EN.
package ssp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        SHIFT
    } tx_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_TX_DEPTH   = 4;
    localparam int DEF_RX_DEPTH   = 4;
    localparam int DEF_CLK_DIV    = 2;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Counters that must be able to hold the value n itself.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ssp_fifo.sv
// Synchronous FIFO with registered full/empty flags; a push on a full FIFO
// is accepted when a pop happens in the same cycle.
module ssp_fifo
    import ssp_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH = DEF_TX_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == FULL_CNT);
            empty <= (count_next == CW'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/ssp_param.sv
// Parametrised synchronous serial port: bus-fed TX/RX FIFOs, serializer and
// oversampling deserializer. Define SSP_LOOPBACK_EN to add the LPBK input.
module ssp_param
    import ssp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TX_DEPTH   = DEF_TX_DEPTH,
    parameter int RX_DEPTH   = DEF_RX_DEPTH,
    parameter int CLK_DIV    = DEF_CLK_DIV
) (
    input  logic                  PCLK,
    input  logic                  CLEAR,
`ifdef SSP_LOOPBACK_EN
    input  logic                  LPBK,
`endif
    input  logic                  PSEL,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  SSPCLKIN,
    input  logic                  SSPFSSIN,
    input  logic                  SSPRXD,
    output logic                  SSPCLKOUT,
    output logic                  SSPFSSOUT,
    output logic                  SSPTXD,
    output logic                  SSPOE_B,
    output logic                  SSPTXINTR,
    output logic                  SSPRXINTR,
    output logic                  SSPRXOVR
);

    localparam int DW   = DATA_WIDTH;
    localparam int DIVW = cnt_w(CLK_DIV);
    localparam int BW   = cnt_w(DATA_WIDTH);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
    localparam logic [BW-1:0]   TX_LAST  = BW'(DATA_WIDTH);
    localparam logic [BW-1:0]   RX_LAST  = BW'(DATA_WIDTH - 1);

    tx_state_t         state;
    logic [DIVW-1:0]   div_cnt;
    logic [BW-1:0]     tx_bits;
    logic [DW-1:0]     tx_shreg;
    logic              clk_out;
    logic              fss_out;
    logic              txd;
    logic              oe_b;
    logic              period_end;
    logic              word_done;

    logic              tx_push;
    logic              tx_pop;
    logic [DW-1:0]     tx_head;
    logic              tx_full;
    logic              tx_empty;

    logic              rx_clk_src;
    logic              rx_fss_src;
    logic              rx_rxd_src;
    logic [2:0]        clk_sync;
    logic [1:0]        fss_sync;
    logic [1:0]        rxd_sync;
    logic              rx_rise;
    logic              rx_fall;
    logic              rx_sample;
    logic              rx_last;
    logic              rx_armed;
    logic [BW-1:0]     rx_bits;
    logic [DW-2:0]     rx_shreg;
    logic [DW-1:0]     rx_word;
    logic              rx_push;
    logic              rx_pop;
    logic              rd_req;
    logic [DW-1:0]     rx_head;
    logic              rx_full;
    logic              rx_empty;
    logic              rx_ovr;

    ssp_fifo #(.WIDTH(DW), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (PCLK),
        .rst   (CLEAR),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (PWDATA),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    ssp_fifo #(.WIDTH(DW), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (PCLK),
        .rst   (CLEAR),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_word),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign tx_push = PSEL && PWRITE;
    assign rd_req  = PSEL && !PWRITE;
    assign rx_pop  = rd_req && !rx_empty;

    // A serial period begins on the SSPCLKOUT rising edge and ends after its low half.
    assign period_end = (div_cnt == DIV_LAST) && !clk_out;
    assign word_done  = period_end && (tx_bits == TX_LAST);
    assign tx_pop     = !tx_empty &&
                        ((state == IDLE) || ((state == SHIFT) && word_done));

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            state    <= IDLE;
            div_cnt  <= '0;
            tx_bits  <= '0;
            tx_shreg <= '0;
            clk_out  <= 1'b0;
            fss_out  <= 1'b0;
            txd      <= 1'b0;
            oe_b     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    clk_out <= 1'b0;
                    div_cnt <= '0;
                    if (!tx_empty) begin
                        state    <= FRAME;
                        tx_shreg <= tx_head;
                        fss_out  <= 1'b1;
                        clk_out  <= 1'b1;
                    end
                end
                FRAME, SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        clk_out <= ~clk_out;
                    end else begin
                        div_cnt <= div_cnt + DIVW'(1);
                    end
                    if (period_end) begin
                        if (state == FRAME || !word_done) begin
                            state    <= SHIFT;
                            fss_out  <= 1'b0;
                            oe_b     <= 1'b0;
                            txd      <= tx_shreg[DW-1];
                            tx_shreg <= {tx_shreg[DW-2:0], 1'b0};
                            tx_bits  <= (state == FRAME) ? BW'(1) : tx_bits + BW'(1);
                        end else if (!tx_empty) begin
                            state    <= FRAME;
                            tx_shreg <= tx_head;
                            fss_out  <= 1'b1;
                            txd      <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            oe_b    <= 1'b1;
                            txd     <= 1'b0;
                            clk_out <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SSP_LOOPBACK_EN
    assign rx_clk_src = LPBK ? clk_out : SSPCLKIN;
    assign rx_fss_src = LPBK ? fss_out : SSPFSSIN;
    assign rx_rxd_src = LPBK ? txd     : SSPRXD;
`else
    assign rx_clk_src = SSPCLKIN;
    assign rx_fss_src = SSPFSSIN;
    assign rx_rxd_src = SSPRXD;
`endif

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            clk_sync <= '0;
            fss_sync <= '0;
            rxd_sync <= '0;
        end else begin
            clk_sync <= {clk_sync[1:0], rx_clk_src};
            fss_sync <= {fss_sync[0], rx_fss_src};
            rxd_sync <= {rxd_sync[0], rx_rxd_src};
        end
    end

    // Falling edges inside the frame-sync period belong to the header, not the word.
    assign rx_rise   = clk_sync[1] && !clk_sync[2];
    assign rx_fall   = !clk_sync[1] && clk_sync[2];
    assign rx_sample = rx_fall && rx_armed && !fss_sync[1];
    assign rx_last   = rx_sample && (rx_bits == RX_LAST);
    assign rx_word   = {rx_shreg, rxd_sync[1]};
    assign rx_push   = rx_last && (!rx_full || rx_pop);

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            rx_armed <= 1'b0;
            rx_bits  <= '0;
            rx_shreg <= '0;
            rx_ovr   <= 1'b0;
        end else begin
            if (rx_rise && fss_sync[1]) begin
                rx_armed <= 1'b1;
                rx_bits  <= '0;
            end else if (rx_sample) begin
                rx_shreg <= rx_word[DW-2:0];
                rx_bits  <= rx_bits + BW'(1);
                if (rx_last) begin
                    rx_armed <= 1'b0;
                    rx_bits  <= '0;
                    if (rx_full && !rx_pop) begin
                        rx_ovr <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            PRDATA <= '0;
        end else if (rd_req) begin
            PRDATA <= rx_empty ? '0 : rx_head;
        end
    end

    assign SSPCLKOUT = clk_out;
    assign SSPFSSOUT = fss_out;
    assign SSPTXD    = txd;
    assign SSPOE_B   = oe_b;
    assign SSPTXINTR = tx_full;
    assign SSPRXINTR = rx_full;
    assign SSPRXOVR  = rx_ovr;

endmodule

// File: tb/tb_ssp_param.sv
// Self-checking bench for ssp_param: directed TX timing, FIFO limits, RX framing,
// overrun and (with SSP_LOOPBACK_EN) internal loopback.
module tb_ssp_param;

    localparam int DW       = 8;
    localparam int TX_DEPTH = 4;
    localparam int RX_DEPTH = 4;
    localparam int CLK_DIV  = 2;
    localparam int BIT_CYC  = 2 * CLK_DIV;

    logic          PCLK;
    logic          CLEAR;
`ifdef SSP_LOOPBACK_EN
    logic          LPBK;
`endif
    logic          PSEL;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          SSPCLKIN;
    logic          SSPFSSIN;
    logic          SSPRXD;
    logic          SSPCLKOUT;
    logic          SSPFSSOUT;
    logic          SSPTXD;
    logic          SSPOE_B;
    logic          SSPTXINTR;
    logic          SSPRXINTR;
    logic          SSPRXOVR;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mon_q[$];
    logic [DW-1:0] mon_word;
    int            mon_cnt;
    logic [DW-1:0] rx_model[$];

    ssp_param #(
        .DATA_WIDTH (DW),
        .TX_DEPTH   (TX_DEPTH),
        .RX_DEPTH   (RX_DEPTH),
        .CLK_DIV    (CLK_DIV)
    ) dut (
        .PCLK      (PCLK),
        .CLEAR     (CLEAR),
`ifdef SSP_LOOPBACK_EN
        .LPBK      (LPBK),
`endif
        .PSEL      (PSEL),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .SSPCLKIN  (SSPCLKIN),
        .SSPFSSIN  (SSPFSSIN),
        .SSPRXD    (SSPRXD),
        .SSPCLKOUT (SSPCLKOUT),
        .SSPFSSOUT (SSPFSSOUT),
        .SSPTXD    (SSPTXD),
        .SSPOE_B   (SSPOE_B),
        .SSPTXINTR (SSPTXINTR),
        .SSPRXINTR (SSPRXINTR),
        .SSPRXOVR  (SSPRXOVR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #600000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    // Serial line decoder: a word is the DW bits seen on SSPCLKOUT falling edges after frame sync.
    always @(negedge SSPCLKOUT or posedge CLEAR) begin
        if (CLEAR) begin
            mon_cnt = 0;
        end else if (SSPFSSOUT) begin
            mon_cnt = 0;
        end else if (!SSPOE_B) begin
            mon_word = {mon_word[DW-2:0], SSPTXD};
            mon_cnt++;
            if (mon_cnt == DW) begin
                mon_q.push_back(mon_word);
                mon_cnt = 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [DW-1:0] data, output logic [DW-1:0] rdata);
        PSEL   = 1'b1;
        PWRITE = wr;
        PWDATA = data;
        @(negedge PCLK);
        PSEL   = 1'b0;
        PWRITE = 1'b0;
        rdata  = PRDATA;
    endtask

    task automatic waitFssRise(input string tag);
        int n;
        n = 0;
        while (!SSPFSSOUT && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        checkOutput(tag, SSPFSSOUT, 1);
    endtask

    task automatic rxFrame(input logic [DW-1:0] word, input int nbits);
        SSPFSSIN = 1'b1;
        SSPCLKIN = 1'b0;
        repeat (4) @(negedge PCLK);
        SSPCLKIN = 1'b1;
        repeat (4) @(negedge PCLK);
        SSPCLKIN = 1'b0;
        repeat (4) @(negedge PCLK);
        for (int i = 0; i < nbits; i++) begin
            SSPFSSIN = 1'b0;
            SSPRXD   = word[DW-1-i];
            SSPCLKIN = 1'b1;
            repeat (4) @(negedge PCLK);
            SSPCLKIN = 1'b0;
            repeat (4) @(negedge PCLK);
        end
        SSPFSSIN = 1'b0;
        SSPRXD   = 1'b0;
        repeat (2) @(negedge PCLK);
    endtask

    function automatic logic [DW-1:0] popMon();
        if (mon_q.size() == 0) return 'x;
        return mon_q.pop_front();
    endfunction

    initial begin
        logic [DW-1:0] rd;
        logic [DW-1:0] w;
        logic [DW-1:0] w0;
        logic [DW-1:0] fill [TX_DEPTH+1];
        logic          prev;
        logic          exp_ovr;
        logic          done;
        int            n;
        int            ones;
        int            oe_low;
        int            exp_bit;

        CLEAR    = 1'b1;
        PSEL     = 1'b0;
        PWRITE   = 1'b0;
        PWDATA   = '0;
        SSPCLKIN = 1'b0;
        SSPFSSIN = 1'b0;
        SSPRXD   = 1'b0;
`ifdef SSP_LOOPBACK_EN
        LPBK     = 1'b0;
`endif

        repeat (3) @(negedge PCLK);
        CLEAR = 1'b0;
        @(negedge PCLK);
        checkOutput("rst_clkout", SSPCLKOUT, 0);
        checkOutput("rst_fssout", SSPFSSOUT, 0);
        checkOutput("rst_txd", SSPTXD, 0);
        checkOutput("rst_oe_b", SSPOE_B, 1);
        checkOutput("rst_txintr", SSPTXINTR, 0);
        checkOutput("rst_rxintr", SSPRXINTR, 0);
        checkOutput("rst_rxovr", SSPRXOVR, 0);
        checkOutput("rst_prdata", PRDATA, 0);
        applyStimulus(1'b0, '0, rd);
        checkOutput("rst_rx_empty_read", rd, 0);

        $display("[TB] single word 0xA5 timing");
        mon_q.delete();
        applyStimulus(1'b1, 8'hA5, rd);
        waitFssRise("a5_fss_start");
        n = 0;
        while (SSPFSSOUT && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        checkOutput("a5_fss_len", n, BIT_CYC);
        oe_low = 0;
        for (int i = 0; i < DW; i++) begin
            exp_bit = (8'hA5 >> (DW - 1 - i)) & 1;
            ones = 0;
            repeat (BIT_CYC) begin
                if (SSPTXD === 1'b1) ones++;
                if (SSPOE_B === 1'b0) oe_low++;
                @(negedge PCLK);
            end
            checkOutput($sformatf("a5_bit%0d_ones", i), ones, exp_bit * BIT_CYC);
        end
        checkOutput("a5_oe_low_cycles", oe_low, DW * BIT_CYC);
        checkOutput("a5_oe_end", SSPOE_B, 1);
        checkOutput("a5_txd_end", SSPTXD, 0);
        checkOutput("a5_clkout_idle", SSPCLKOUT, 0);
        checkOutput("a5_decoded", popMon(), 8'hA5);

        $display("[TB] back-to-back 0x3C 0xC3");
        mon_q.delete();
        applyStimulus(1'b1, 8'h3C, rd);
        applyStimulus(1'b1, 8'hC3, rd);
        waitFssRise("b2b_fss1");
        n = 0;
        prev = 1'b1;
        done = 1'b0;
        while (!done && n < 100) begin
            @(negedge PCLK);
            n++;
            if (!prev && SSPFSSOUT) done = 1'b1;
            prev = SSPFSSOUT;
        end
        checkOutput("b2b_frame_spacing", n, BIT_CYC * (DW + 1));
        checkOutput("b2b_oe_held", SSPOE_B, 0);
        repeat (BIT_CYC * (DW + 1)) @(negedge PCLK);
        checkOutput("b2b_oe_end", SSPOE_B, 1);
        checkOutput("b2b_count", mon_q.size(), 2);
        checkOutput("b2b_word0", popMon(), 8'h3C);
        checkOutput("b2b_word1", popMon(), 8'hC3);

        $display("[TB] TX FIFO fill while busy");
        mon_q.delete();
        w0 = DW'($urandom);
        for (int k = 0; k <= TX_DEPTH; k++) fill[k] = DW'($urandom);
        applyStimulus(1'b1, w0, rd);
        waitFssRise("fill_fss");
        for (int k = 0; k <= TX_DEPTH; k++) begin
            if (k == TX_DEPTH - 1) checkOutput("txintr_before_full", SSPTXINTR, 0);
            if (k == TX_DEPTH) checkOutput("txintr_full", SSPTXINTR, 1);
            applyStimulus(1'b1, fill[k], rd);
        end
        checkOutput("txintr_after_drop", SSPTXINTR, 1);
        n = 0;
        while (mon_q.size() < TX_DEPTH + 1 && n < 600) begin
            @(negedge PCLK);
            n++;
        end
        repeat (6) @(negedge PCLK);
        checkOutput("fill_count", mon_q.size(), TX_DEPTH + 1);
        checkOutput("fill_word_first", popMon(), w0);
        for (int k = 0; k < TX_DEPTH; k++) begin
            checkOutput($sformatf("fill_word%0d", k), popMon(), fill[k]);
        end
        checkOutput("fill_txintr_clear", SSPTXINTR, 0);
        checkOutput("fill_oe_end", SSPOE_B, 1);

        $display("[TB] reset mid-frame");
        mon_q.delete();
        applyStimulus(1'b1, DW'($urandom), rd);
        waitFssRise("midrst_fss");
        repeat (10) @(negedge PCLK);
        #2 CLEAR = 1'b1;
        #1;
        checkOutput("midrst_oe_b", SSPOE_B, 1);
        checkOutput("midrst_clkout", SSPCLKOUT, 0);
        checkOutput("midrst_txd", SSPTXD, 0);
        repeat (3) @(negedge PCLK);
        CLEAR = 1'b0;
        repeat (60) @(negedge PCLK);
        checkOutput("midrst_no_word", mon_q.size(), 0);
        checkOutput("midrst_fss_idle", SSPFSSOUT, 0);

        $display("[TB] RX frame 0x81 after aborted partial word");
        rxFrame(DW'($urandom), 3);
        rxFrame(8'h81, DW);
        applyStimulus(1'b0, '0, rd);
        checkOutput("rx81_read", rd, 8'h81);
        applyStimulus(1'b0, '0, rd);
        checkOutput("rx81_empty_read", rd, 0);
        checkOutput("rx81_no_ovr", SSPRXOVR, 0);

        $display("[TB] RX overrun with random frames");
        rx_model.delete();
        exp_ovr = 1'b0;
        for (int f = 0; f <= RX_DEPTH; f++) begin
            w = DW'($urandom);
            rxFrame(w, DW);
            if (rx_model.size() < RX_DEPTH) rx_model.push_back(w);
            else exp_ovr = 1'b1;
            checkOutput($sformatf("rx_full_after_%0d", f + 1), SSPRXINTR, (rx_model.size() == RX_DEPTH));
            checkOutput($sformatf("rx_ovr_after_%0d", f + 1), SSPRXOVR, exp_ovr);
        end
        for (int k = 0; k < RX_DEPTH; k++) begin
            applyStimulus(1'b0, '0, rd);
            checkOutput($sformatf("rx_read%0d", k), rd, rx_model.pop_front());
            if (k == 0) checkOutput("rx_full_drop", SSPRXINTR, 0);
        end
        applyStimulus(1'b0, '0, rd);
        checkOutput("rx_drained_read", rd, 0);
        checkOutput("rx_ovr_sticky", SSPRXOVR, 1);

`ifdef SSP_LOOPBACK_EN
        $display("[TB] loopback 0x5A");
        LPBK = 1'b1;
        @(negedge PCLK);
        applyStimulus(1'b1, 8'h5A, rd);
        repeat (80) @(negedge PCLK);
        applyStimulus(1'b0, '0, rd);
        checkOutput("lpbk_read", rd, 8'h5A);
        LPBK = 1'b0;
`endif

        CLEAR = 1'b1;
        repeat (3) @(negedge PCLK);
        CLEAR = 1'b0;
        @(negedge PCLK);
        checkOutput("final_ovr_cleared", SSPRXOVR, 0);
        checkOutput("final_rxintr", SSPRXINTR, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
